// File: rtl/mem_pkg.sv
// Shared definitions for the memory command path (mem_req_issuer, mem_controller):
// FSM states, default bus widths and the request-entry layout {write, addr, data}.
package mem_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    // Entry layout: write flag in the MSB, then address, then data in the LSBs.
    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/mem_req_issuer_if.sv
// Host request/response and controller command signals of mem_req_issuer.
// slave = issuer side, master = host/controller environment side.
interface mem_req_issuer_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  ctl_wr_en;
    logic                  ctl_rd_en;
    logic [ADDR_WIDTH-1:0] ctl_addr;
    logic [DATA_WIDTH-1:0] ctl_wr_data;
    logic [DATA_WIDTH-1:0] ctl_rd_data;
    logic                  ctl_ready;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ctl_rd_data, ctl_ready,
        output req_ready, rsp_valid, rsp_rdata, ctl_wr_en, ctl_rd_en, ctl_addr, ctl_wr_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, ctl_rd_data, ctl_ready,
        input  req_ready, rsp_valid, rsp_rdata, ctl_wr_en, ctl_rd_en, ctl_addr, ctl_wr_data
    );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with combinational head output and occupancy count.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module mem_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_req_issuer.sv
// Buffers host read/write requests and issues them one at a time to mem_controller.
// Optional wait timeout enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_req_issuer
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_req_issuer_if.slave        bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err
);
    localparam int unsigned ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("mem_req_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES > 0");
    end

    mem_state_t            state, state_n;
    logic                  fifo_full, fifo_empty;
    logic                  push, issue, expire;
    logic [ENTRY_W-1:0]    head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic                  wr_en_q, wr_en_n;
    logic                  rd_en_q, rd_en_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic                  cur_write_q, cur_write_n;
    logic                  rsp_valid_q, rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;

    assign push          = bus.req_valid && !fifo_full;
    assign bus.req_ready = !fifo_full;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .din   ({bus.req_write, bus.req_addr, bus.req_wdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_write, head_addr, head_data} = head;

    // Completion and the next issue share an edge, giving one command per 3 cycles.
    always_comb begin
        state_n     = state;
        issue       = 1'b0;
        wr_en_n     = 1'b0;
        rd_en_n     = 1'b0;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        cur_write_n = cur_write_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        case (state)
            S_IDLE: issue = !fifo_empty;
            S_WAIT: begin
                if (bus.ctl_ready) begin
                    state_n = S_IDLE;
                    issue   = !fifo_empty;
                    if (!cur_write_q) begin
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = bus.ctl_rd_data;
                    end
                end else if (expire) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (issue) begin
            state_n     = S_WAIT;
            wr_en_n     = head_write;
            rd_en_n     = !head_write;
            addr_n      = head_addr;
            wdata_n     = head_data;
            cur_write_n = head_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cur_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_n;
            wr_en_q     <= wr_en_n;
            rd_en_q     <= rd_en_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            cur_write_q <= cur_write_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Counts S_WAIT edges without ctl_ready; the TIMEOUT_CYCLES-th such edge expires.
    assign expire = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (issue) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !bus.ctl_ready) begin
                if (expire) timeout_q <= 1'b1;
                else        wait_cnt  <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy            = (state == S_WAIT);
    assign bus.ctl_wr_en   = wr_en_q;
    assign bus.ctl_rd_en   = rd_en_q;
    assign bus.ctl_addr    = addr_q;
    assign bus.ctl_wr_data = wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Self-checking bench for mem_req_issuer: queue-based reference model, RAM-backed
// controller stand-in with random latency, directed and random stimulus.
module tb_mem_req_issuer;
    import mem_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TOUT  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_issuer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   timeout_err;

    mem_req_issuer #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    req_t          q[$];
    req_t          cur;
    bit            inflight = 0;
    int            wcnt     = 0;
    int            pushpop_at2 = 0;
    bit            e_wr = 0, e_rd = 0, e_rsp = 0, e_terr = 0;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] e_rdata = '0;
    logic [DW-1:0] ref_mem [1 << AW];

    always @(posedge clk or posedge rst) begin
        bit accept, done, dropped;
        int sz;
        if (rst) begin
            q.delete();
            inflight = 0; wcnt = 0;
            e_wr = 0; e_rd = 0; e_rsp = 0; e_terr = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            sz      = q.size();
            accept  = bus.req_valid && (sz < DEPTH);
            done    = 0;
            dropped = 0;
            e_wr = 0; e_rd = 0; e_rsp = 0;
            if (inflight) begin
                if (bus.ctl_ready) done = 1;
                else begin
                    wcnt++;
`ifdef MEM_REQ_TIMEOUT_EN
                    if (wcnt >= TOUT) dropped = 1;
`endif
                end
            end
            if (done) begin
                if (cur.w) ref_mem[cur.a] = cur.d;
                else begin
                    e_rsp   = 1;
                    e_rdata = ref_mem[cur.a];
                end
                inflight = 0;
            end
            if (dropped) begin
                e_terr   = 1;
                inflight = 0;
            end
            if (sz > 0 && !inflight && !dropped) begin
                cur      = q.pop_front();
                inflight = 1;
                wcnt     = 0;
                e_addr   = cur.a;
                e_wdata  = cur.d;
                e_wr     = cur.w;
                e_rd     = !cur.w;
                if (accept && sz == 2) pushpop_at2++;
            end
            if (accept) q.push_back({bus.req_write, bus.req_addr, bus.req_wdata});
        end
    end

    task automatic check();
        chk("req_ready",   bus.req_ready,   (q.size() < DEPTH));
        chk("fifo_count",  fifo_count,      q.size());
        chk("busy",        busy,            inflight);
        chk("ctl_wr_en",   bus.ctl_wr_en,   e_wr);
        chk("ctl_rd_en",   bus.ctl_rd_en,   e_rd);
        chk("ctl_addr",    bus.ctl_addr,    e_addr);
        chk("ctl_wr_data", bus.ctl_wr_data, e_wdata);
        chk("rsp_valid",   bus.rsp_valid,   e_rsp);
        chk("rsp_rdata",   bus.rsp_rdata,   e_rdata);
        chk("timeout_err", timeout_err,     e_terr);
        chk("strobe_excl", bus.ctl_wr_en & bus.ctl_rd_en, 1'b0);
    endtask

    // ---------------- controller stand-in ----------------
    logic [DW-1:0] cram [1 << AW];
    bit outstanding = 0;
    int ccnt = 0;
    bit stall = 0, spur_en = 0, saw_full = 0;
    int lat_lo = 2, lat_hi = 2;

    task automatic ctl_step();
        bus.ctl_ready = 1'b0;
        if (rst) begin
            outstanding = 0;
        end else if (outstanding) begin
            ccnt--;
            if (ccnt == 0) begin
                bus.ctl_ready = 1'b1;
                outstanding   = 0;
            end
        end else if (!stall && (bus.ctl_wr_en || bus.ctl_rd_en)) begin
            outstanding = 1;
            ccnt        = $urandom_range(lat_hi, lat_lo);
            if (bus.ctl_wr_en) cram[bus.ctl_addr] = bus.ctl_wr_data;
            else               bus.ctl_rd_data = cram[bus.ctl_addr];
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            bus.ctl_ready   = 1'b1;
            bus.ctl_rd_data = DW'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        if (!bus.req_ready && fifo_count == DEPTH) saw_full = 1;
        ctl_step();
    endtask

    // Holds the request until it is accepted; leaves req_valid asserted on return.
    task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 100; i++) begin
            acc = bus.req_ready;
            tick();
            if (acc) return;
        end
        chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 300 && (fifo_count != 0 || busy); i++) tick();
        chk(name, (fifo_count == 0 && !busy), 1'b1);
    endtask

    task automatic wait_rsp(input string name, input logic [DW-1:0] exp);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) tick();
        chk({name, "_seen"}, bus.rsp_valid, 1'b1);
        chk({name, "_data"}, bus.rsp_rdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
            cram[i]    = '0;
        end
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.ctl_ready   = 1'b0;
        bus.ctl_rd_data = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req_ready",  bus.req_ready, 1'b1);
        chk("rst_fifo_count", fifo_count,    0);
        chk("rst_busy",       busy,          1'b0);
        chk("rst_rsp_valid",  bus.rsp_valid, 1'b0);

        // single write 0x12 <= 0xA5
        push_req(1'b1, 8'h12, 8'hA5);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.ctl_wr_en; i++) tick();
        chk("wr_strobe",     bus.ctl_wr_en,   1'b1);
        chk("wr_addr",       bus.ctl_addr,    8'h12);
        chk("wr_data",       bus.ctl_wr_data, 8'hA5);
        chk("wr_no_rd",      bus.ctl_rd_en,   1'b0);
        tick();
        chk("wr_pulse_1cyc", bus.ctl_wr_en,   1'b0);
        chk("wr_addr_held",  bus.ctl_addr,    8'h12);
        chk("wr_data_held",  bus.ctl_wr_data, 8'hA5);
        drain("drain_write");
        chk("model_mem_12", ref_mem[8'h12], 8'hA5);

        // read back
        push_req(1'b0, 8'h12, 8'h00);
        wait_rsp("rd_12", 8'hA5);
        drain("drain_read");

        // burst of 6 with a slow controller fills the FIFO
        lat_lo = 6; lat_hi = 6; saw_full = 0;
        for (int i = 0; i < 6; i++) push_req(i[0], AW'(8'h20 + i / 2), DW'(8'h40 + i));
        drain("drain_burst");
        chk("burst_full_seen", saw_full, 1'b1);

        // random traffic
        lat_lo = 1; lat_hi = 4; spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid = $urandom_range(0, 1);
            bus.req_write = $urandom_range(0, 1);
            bus.req_addr  = AW'($urandom_range(0, 7));
            bus.req_wdata = DW'($urandom);
            tick();
        end
        spur_en = 0;
        drain("drain_random");
        chk("pushpop_at2_seen", (pushpop_at2 > 0), 1'b1);

        // reset during the wait phase of a read
        lat_lo = 4; lat_hi = 4;
        push_req(1'b0, 8'h12, 8'h00);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.ctl_rd_en; i++) tick();
        tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        outstanding = 0;
        bus.ctl_ready = 1'b0;
        #1;
        chk("mrst_req_ready",  bus.req_ready,   1'b1);
        chk("mrst_fifo_count", fifo_count,      0);
        chk("mrst_busy",       busy,            1'b0);
        chk("mrst_rsp_valid",  bus.rsp_valid,   1'b0);
        chk("mrst_rd_en",      bus.ctl_rd_en,   1'b0);
        chk("mrst_addr",       bus.ctl_addr,    0);
        chk("mrst_wdata",      bus.ctl_wr_data, 0);
        chk("mrst_rdata",      bus.rsp_rdata,   0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        lat_lo = 2; lat_hi = 2;
        push_req(1'b0, 8'h12, 8'h00);
        wait_rsp("post_rst_rd", 8'hA5);
        drain("drain_post_rst");

`ifdef MEM_REQ_TIMEOUT_EN
        stall = 1;
        push_req(1'b0, 8'h12, 8'h00);
        push_req(1'b1, 8'h13, 8'h5A);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 60 && !timeout_err; i++) tick();
        chk("timeout_set", timeout_err, 1'b1);
        drain("drain_timeout");
        stall = 0;
        spur_en = 1;
        repeat (20) tick();
        spur_en = 0;
        chk("timeout_sticky", timeout_err, 1'b1);
        push_req(1'b0, 8'h12, 8'h00);
        wait_rsp("after_to_rd", 8'hA5);
        drain("drain_after_to");
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_issuer.md
Name: mem_req_issuer

Overview:
- Upstream command stage for `mem_controller`.
- Accepts write/read requests from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time to `mem_controller` as single-cycle `wr_en`/`rd_en` strobes, holding address and data stable until the controller's `ready` pulse.
- Returns read data to the host as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 8, address width; matches `mem_controller`.
- DATA_WIDTH, 8, data width; matches `mem_controller`.
- DEPTH, 4, request FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 16, wait limit for `ctl_ready` (used only with `MEM_REQ_TIMEOUT_EN`).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  host request present
- req_ready  out  1  FIFO can accept; equals !full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: read completed
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- ctl_wr_en  out  1  to controller wr_en
- ctl_rd_en  out  1  to controller rd_en
- ctl_addr  out  ADDR_WIDTH  to controller addr
- ctl_wr_data  out  DATA_WIDTH  to controller wr_data
- ctl_rd_data  in  DATA_WIDTH  from controller rd_data
- ctl_ready  in  1  from controller ready
- busy  out  1  high in S_WAIT
- fifo_count  out  $clog2(DEPTH)+1  entries queued, not yet issued
- timeout_err  out  1  sticky timeout flag; tied 0 without macro

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. FIFO is emptied and FSM goes to S_IDLE.
- Reset mid-operation aborts the in-flight command without a response. `mem_controller` shares the same `rst`.
- FIFO push: on req_valid && req_ready; stores {write, addr, wdata}.
- req_ready is !full, purely from the count. A same-cycle pop does not allow a push when full.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - S_IDLE: if FIFO is non-empty, pop the head and register its fields into ctl_addr/ctl_wr_data. Assert ctl_wr_en or ctl_rd_en for exactly one cycle (the next cycle), then go to S_WAIT. If the FIFO is empty, stay.
  - S_WAIT: strobes are 0. ctl_addr and ctl_wr_data are held unchanged.
    - On ctl_ready, go to S_IDLE.
    - If the command was a read, register rsp_rdata <= ctl_rd_data and pulse rsp_valid for one cycle.
    - Writes produce no response.
- Timing (issue decision at edge E0):
  - strobe high in cycle after E0;
  - controller ready arrives 2 cycles later;
  - rsp_valid appears 1 cycle after ready;
  - next issue can occur on the same edge that registers rsp_valid.
  - Steady-state rate: 1 command per 3 cycles.
- ctl_ready while in S_IDLE is ignored.
- No host backpressure on responses: rsp_valid is a pulse only.
- ctl_wr_en and ctl_rd_en are never high together, and never high outside the single strobe cycle.
- Commands complete strictly in FIFO order.

Optional Feature:
- MEM_REQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to S_WAIT.
  - If TIMEOUT_CYCLES cycles elapse in S_WAIT without ctl_ready, set timeout_err (sticky until rst), drop the command with no rsp_valid, and return to S_IDLE.
  - A ctl_ready arriving later is ignored.
- Not defined: no counter; S_WAIT waits indefinitely; timeout_err is constant 0.

Decomposition:
- Shared package `mem_pkg`:
  - FSM state encoding (S_IDLE, S_WAIT);
  - request-entry field widths/layout (`{write, addr, data}`);
  - default ADDR_WIDTH/DATA_WIDTH constants, also used by `mem_controller`.
- One sub-module: `mem_req_fifo`, a synchronous FIFO with DEPTH and WIDTH params and push/pop/full/empty/count.

Test Plan:
- Single write addr 0x12, data 0xA5 → ctl_wr_en high exactly 1 cycle with ctl_addr = 0x12 and ctl_wr_data = 0xA5 held until ctl_ready; no rsp_valid.
- Write 0x12 ← 0xA5, then read 0x12 (controller plus a simple RAM model) → one rsp_valid pulse with rsp_rdata = 0xA5; read strobe never overlaps the write.
- Push 5 requests back-to-back with DEPTH = 4 while controller is busy → req_ready drops at fifo_count = 4; fifth accepted only after first pop; all 5 complete in order.
- Push and issue-pop in the same cycle with count = 2 → count stays 2; the pushed entry is issued in order later.
- Assert rst during S_WAIT of a read → all outputs return to reset values next cycle; fifo_count = 0; no rsp_valid ever; new request after reset completes normally.
- With MEM_REQ_TIMEOUT_EN and ctl_ready held 0 → timeout_err = 1 after 16 wait cycles; FSM proceeds to next queued command; a late ctl_ready is ignored.
